instruction_loader: RTL and testbench

INSTRUCTION_LOADER -- requirements
Module: instruction_loader

---
 rtl/instruction_loader.sv | 170 +++++++++++++++++
 tb/tb_instruction_loader.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_loader.sv
// Instruction loader: accepts 32-bit words from a valid/ready source and
// writes them big-endian, one byte per cycle, into a byte-wide instruction
// store starting at a word-aligned base address.
module instruction_loader #(
    parameter int unsigned MEM_BYTES = 2500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [15:0] word_count,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_byte,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] words_written
);

    localparam int unsigned AW = 32;
    localparam int unsigned CW = 16;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 8;
    localparam int unsigned IW = 2;

    // Last valid byte address, widened so the range check cannot wrap.
    localparam logic [AW:0] LAST_ADDR = (AW + 1)'(MEM_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_WORD,
        WRITE,
        DONE,
        ERR
    } state_t;

    state_t          state, state_n;
    logic [AW-1:0]   cur_addr, cur_addr_n;
    logic [CW-1:0]   remaining, remaining_n;
    logic [IW-1:0]   byte_idx, byte_idx_n;
    logic [DW-1:0]   word, word_n;
    logic [CW-1:0]   words_written_n;
    logic            mem_we_n;
    logic [AW-1:0]   mem_addr_n;
    logic [BW-1:0]   mem_byte_n;
    logic            busy_n;
    logic            done_n;
    logic            error_n;
    logic            in_range;

    // Source may hand over a word only while waiting for one.
    assign in_ready = (state == WAIT_WORD);

    // Whole word (cur_addr..cur_addr+3) must fit inside the store.
    assign in_range = (({1'b0, cur_addr} + (AW + 1)'(3)) <= LAST_ADDR);

    // State and datapath registers; reset wins over everything, even mid-word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            cur_addr      <= '0;
            remaining     <= '0;
            byte_idx      <= '0;
            word          <= '0;
            words_written <= '0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_byte      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            state         <= state_n;
            cur_addr      <= cur_addr_n;
            remaining     <= remaining_n;
            byte_idx      <= byte_idx_n;
            word          <= word_n;
            words_written <= words_written_n;
            mem_we        <= mem_we_n;
            mem_addr      <= mem_addr_n;
            mem_byte      <= mem_byte_n;
            busy          <= busy_n;
            done          <= done_n;
            error         <= error_n;
        end
    end

    // Next-state logic; outputs are decoded from the next state so their
    // registered copies line up with the state they describe.
    always_comb begin
        state_n         = state;
        cur_addr_n      = cur_addr;
        remaining_n     = remaining;
        byte_idx_n      = byte_idx;
        word_n          = word;
        words_written_n = words_written;
        mem_we_n        = 1'b0;
        mem_addr_n      = '0;
        mem_byte_n      = '0;
        busy_n          = 1'b0;
        done_n          = 1'b0;
        error_n         = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    cur_addr_n      = base_addr;
                    remaining_n     = word_count;
                    words_written_n = '0;
                    if (base_addr[1:0] != 2'b00) begin
                        state_n = ERR;
                    end else if (word_count == '0) begin
                        state_n = DONE;
                    end else begin
                        state_n = WAIT_WORD;
                    end
                end
            end
            WAIT_WORD: begin
                if (in_valid) begin
                    if (in_range) begin
                        word_n     = in_data;
                        byte_idx_n = '0;
                        state_n    = WRITE;
                    end else begin
                        state_n = ERR;
                    end
                end
            end
            WRITE: begin
                byte_idx_n = byte_idx + IW'(1);
                if (byte_idx == IW'(3)) begin
                    cur_addr_n      = cur_addr + AW'(4);
                    remaining_n     = remaining - CW'(1);
                    words_written_n = words_written + CW'(1);
                    state_n         = (remaining == CW'(1)) ? DONE : WAIT_WORD;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            ERR: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n  = (state_n != IDLE);
        done_n  = (state_n == DONE);
        error_n = (state_n == ERR);

        if (state_n == WRITE) begin
            mem_we_n   = 1'b1;
            mem_addr_n = cur_addr_n + AW'(byte_idx_n);
            case (byte_idx_n)
                2'd0:    mem_byte_n = word_n[31:24];
                2'd1:    mem_byte_n = word_n[23:16];
                2'd2:    mem_byte_n = word_n[15:8];
                default: mem_byte_n = word_n[7:0];
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Directed bench for instruction_loader: single linear stimulus sequence,
// immediate assertions at every check point.
module tb_instruction_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] word_count;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_byte;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_written;

    int tests = 0;
    int fails = 0;

    // Write log captured from the store interface.
    int          nwr = 0;
    logic [31:0] wa [0:63];
    logic [7:0]  wd [0:63];
    int          wr0;

    instruction_loader #(.MEM_BYTES(2500)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .base_addr     (base_addr),
        .word_count    (word_count),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_byte      (mem_byte),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    // Log every byte write seen at a clock edge.
    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            if (nwr < 64) begin
                wa[nwr] <= mem_addr;
                wd[nwr] <= mem_byte;
            end
            nwr <= nwr + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare 8 logged writes starting at log index idx against two
    // big-endian words stored from addr0 upward.
    task automatic chk_words(input string tag, input int idx, input logic [31:0] addr0,
                             input logic [31:0] wa_exp, input logic [31:0] wb_exp);
        logic [31:0] w;
        logic [7:0]  b;
        for (int k = 0; k < 8; k++) begin
            w = (k < 4) ? wa_exp : wb_exp;
            b = 8'(w >> (24 - 8 * (k % 4)));
            chk($sformatf("%s_addr%0d", tag, k), wa[idx + k], addr0 + 32'(k));
            chk($sformatf("%s_byte%0d", tag, k), 32'(wd[idx + k]), 32'(b));
        end
    endtask

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        base_addr  = '0;
        word_count = '0;
        in_data    = '0;
        in_valid   = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_mem_we",   32'(mem_we),   32'd0);
        chk("rst_mem_addr", mem_addr,      32'd0);
        chk("rst_mem_byte", 32'(mem_byte), 32'd0);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_done",     32'(done),     32'd0);
        chk("rst_error",    32'(error),    32'd0);
        chk("rst_ww",       32'(words_written), 32'd0);
        rst = 1'b1;
        tick();

        // Two-word load from 0, in_valid held high
        wr0        = nwr;
        start      = 1'b1;
        base_addr  = 32'h0;
        word_count = 16'd2;
        in_data    = 32'h8C010004;
        in_valid   = 1'b1;
        tick();                                   // cycle 1: WAIT_WORD
        start = 1'b0;
        chk("l2_c1_in_ready", 32'(in_ready), 32'd1);
        chk("l2_c1_busy",     32'(busy),     32'd1);
        chk("l2_c1_mem_we",   32'(mem_we),   32'd0);
        tick();                                   // cycle 2: first byte
        chk("l2_c2_mem_we",   32'(mem_we),   32'd1);
        chk("l2_c2_addr",     mem_addr,      32'd0);
        chk("l2_c2_byte",     32'(mem_byte), 32'h8C);
        chk("l2_c2_in_ready", 32'(in_ready), 32'd0);
        in_data = 32'h00221820;
        repeat (4) tick();                        // cycle 6: back to WAIT_WORD
        chk("l2_c6_in_ready", 32'(in_ready), 32'd1);
        chk("l2_c6_mem_we",   32'(mem_we),   32'd0);
        chk("l2_c6_ww",       32'(words_written), 32'd1);
        repeat (4) tick();                        // cycle 10: last byte
        chk("l2_c10_addr",    mem_addr,      32'd7);
        chk("l2_c10_byte",    32'(mem_byte), 32'h20);
        chk("l2_c10_done",    32'(done),     32'd0);
        tick();                                   // cycle 11: DONE
        in_valid = 1'b0;
        chk("l2_c11_done",    32'(done),     32'd1);
        chk("l2_c11_mem_we",  32'(mem_we),   32'd0);
        chk("l2_c11_ww",      32'(words_written), 32'd2);
        tick();
        chk("l2_c12_done",    32'(done),     32'd0);
        chk("l2_c12_busy",    32'(busy),     32'd0);
        chk("l2_nwr",         32'(nwr - wr0), 32'd8);
        chk_words("l2", wr0, 32'h0, 32'h8C010004, 32'h00221820);

        // Zero-length load: DONE directly after the start cycle
        wr0        = nwr;
        start      = 1'b1;
        base_addr  = 32'h10;
        word_count = 16'd0;
        tick();
        start = 1'b0;
        chk("z_c1_done",     32'(done),     32'd1);
        chk("z_c1_in_ready", 32'(in_ready), 32'd0);
        chk("z_c1_mem_we",   32'(mem_we),   32'd0);
        chk("z_c1_ww",       32'(words_written), 32'd0);
        tick();
        chk("z_c2_done",     32'(done),     32'd0);
        chk("z_c2_busy",     32'(busy),     32'd0);
        chk("z_nwr",         32'(nwr - wr0), 32'd0);

        // Misaligned base aborts immediately
        wr0        = nwr;
        start      = 1'b1;
        base_addr  = 32'h6;
        word_count = 16'd1;
        tick();
        start = 1'b0;
        chk("mis_c1_error",    32'(error),    32'd1);
        chk("mis_c1_done",     32'(done),     32'd0);
        chk("mis_c1_in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("mis_c2_error",    32'(error),    32'd0);
        chk("mis_ww",          32'(words_written), 32'd0);
        chk("mis_nwr",         32'(nwr - wr0), 32'd0);

        // Load running off the end of the store: third word rejected
        wr0        = nwr;
        start      = 1'b1;
        base_addr  = 32'd2492;
        word_count = 16'd3;
        in_data    = 32'h11223344;
        in_valid   = 1'b1;
        tick();                                   // cycle 1
        start = 1'b0;
        tick();                                   // cycle 2
        chk("end_c2_addr", mem_addr,      32'd2492);
        chk("end_c2_byte", 32'(mem_byte), 32'h11);
        in_data = 32'h55667788;
        repeat (5) tick();                        // cycle 7
        chk("end_c7_addr", mem_addr,      32'd2496);
        in_data = 32'h99AABBCC;
        repeat (4) tick();                        // cycle 11: WAIT_WORD
        chk("end_c11_in_ready", 32'(in_ready), 32'd1);
        chk("end_c11_ww",       32'(words_written), 32'd2);
        tick();                                   // cycle 12: ERR
        in_valid = 1'b0;
        chk("end_c12_error",  32'(error),  32'd1);
        chk("end_c12_mem_we", 32'(mem_we), 32'd0);
        chk("end_c12_done",   32'(done),   32'd0);
        tick();
        chk("end_c13_error",  32'(error),  32'd0);
        chk("end_c13_ww",     32'(words_written), 32'd2);
        chk("end_nwr",        32'(nwr - wr0), 32'd8);
        chk_words("end", wr0, 32'd2492, 32'h11223344, 32'h55667788);

        // Reset in the middle of a word
        wr0        = nwr;
        start      = 1'b1;
        base_addr  = 32'h100;
        word_count = 16'd2;
        in_data    = 32'hDEADBEEF;
        in_valid   = 1'b1;
        tick();                                   // cycle 1
        start = 1'b0;
        repeat (2) tick();                        // cycle 3: byte_idx 1
        chk("rmid_c3_addr", mem_addr,      32'h101);
        chk("rmid_c3_byte", 32'(mem_byte), 32'hAD);
        rst = 1'b0;
        tick();
        rst      = 1'b1;
        in_valid = 1'b0;
        chk("rmid_mem_we",   32'(mem_we),   32'd0);
        chk("rmid_busy",     32'(busy),     32'd0);
        chk("rmid_in_ready", 32'(in_ready), 32'd0);
        chk("rmid_done",     32'(done),     32'd0);
        chk("rmid_error",    32'(error),    32'd0);
        chk("rmid_ww",       32'(words_written), 32'd0);
        tick();
        chk("rmid_post_done",  32'(done),  32'd0);
        chk("rmid_post_error", 32'(error), 32'd0);
        chk("rmid_nwr",        32'(nwr - wr0), 32'd2);

        // Seven-cycle source gap plus a stray start while busy
        wr0        = nwr;
        start      = 1'b1;
        base_addr  = 32'h20;
        word_count = 16'd2;
        in_data    = 32'h8C010004;
        in_valid   = 1'b1;
        tick();                                   // cycle 1
        start = 1'b0;
        tick();                                   // cycle 2: writing word 0
        in_valid = 1'b0;
        in_data  = 32'h00221820;
        repeat (4) tick();                        // cycle 6: gap begins
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("gap%0d_in_ready", i), 32'(in_ready), 32'd1);
            chk($sformatf("gap%0d_mem_we", i),   32'(mem_we),   32'd0);
            if (i == 1) begin
                start      = 1'b1;
                base_addr  = 32'h0;
                word_count = 16'd5;
            end
            if (i == 2) start = 1'b0;
            if (i == 6) in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;                          // cycle 13: second word
        chk("gap_c13_addr", mem_addr,      32'h24);
        chk("gap_c13_byte", 32'(mem_byte), 32'h00);
        repeat (4) tick();                        // cycle 17: DONE
        chk("gap_done", 32'(done), 32'd1);
        chk("gap_ww",   32'(words_written), 32'd2);
        tick();
        chk("gap_idle_busy", 32'(busy), 32'd0);
        chk("gap_nwr",       32'(nwr - wr0), 32'd8);
        chk_words("gap", wr0, 32'h20, 32'h8C010004, 32'h00221820);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
